// File: rtl/lab_disp_pkg.sv
// Shared constants for the lab display blocks: BCD limit and 7-segment patterns {a,b,c,d,e,f,g}.
package lab_disp_pkg;

    localparam logic [3:0] BCD_MAX   = 4'd9;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD up/down digit cell; wrap_out flags a 9->0 or 0->9 step so the next cell can ripple.
module bcd_digit
    import lab_disp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] ld_val,
    output logic [3:0] q,
    output logic       wrap_out
);

    logic [3:0] q_r;
    logic [3:0] q_next_s;
    logic       wrap_s;

    // Next digit value; load wins, and out-of-range load nibbles collapse to zero.
    always_comb begin
        q_next_s = q_r;
        wrap_s   = 1'b0;
        if (load) begin
            q_next_s = (ld_val > BCD_MAX) ? 4'd0 : ld_val;
        end else if (inc) begin
            if (q_r == BCD_MAX) begin
                q_next_s = 4'd0;
                wrap_s   = 1'b1;
            end else begin
                q_next_s = q_r + 4'd1;
            end
        end else if (dec) begin
            if (q_r == 4'd0) begin
                q_next_s = BCD_MAX;
                wrap_s   = 1'b1;
            end else begin
                q_next_s = q_r - 4'd1;
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Digit register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= 4'd0;
        end else begin
            q_r <= q_next_s;
        end
    end

    assign q        = q_r;
    assign wrap_out = wrap_s;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with prescaled ticks, parallel load and a multiplexed 7-segment scan driver.
module bcd_scan_counter
    import lab_disp_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int SEL_W      = 3,
    parameter int TICK_DIV   = 20000000,
    parameter int SCAN_DIV   = 20000,
    parameter int DP_POS     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic                    blank_lz,
    output logic [4*NUM_DIGITS-1:0] count_out,
    output logic                    carry,
    output logic [SEL_W-1:0]        seg7_sel,
    output logic [6:0]              seg7_out,
    output logic                    dpt,
    output logic                    led_com
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PRESC_W-1:0]      presc_r;
    logic [SCAN_W-1:0]       scan_r;
    logic [SEL_W-1:0]        sel_r;
    logic                    carry_r;
    logic                    led_com_r;
    logic                    tick_s;
    logic                    scan_wrap_s;
    logic [4*NUM_DIGITS-1:0] count_s;
    logic [NUM_DIGITS-1:0]   inc_s;
    logic [NUM_DIGITS-1:0]   dec_s;
    logic [NUM_DIGITS-1:0]   wrap_s;
    logic [NUM_DIGITS-1:0]   zero_above_s;
    logic [3:0]              digit_s;
    logic                    blank_s;

    assign tick_s      = enable && (presc_r == PRESC_W'(TICK_DIV - 1));
    assign scan_wrap_s = (scan_r == SCAN_W'(SCAN_DIV - 1));

    // Tick prescaler: frozen while disabled, restarted by a load.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else if (enable) begin
            presc_r <= presc_r + PRESC_W'(1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // Ripple chain: each higher digit steps only when every lower digit wrapped this tick.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        if (g == 0) begin : g_lsd
            assign inc_s[g] = tick_s && up_dn;
            assign dec_s[g] = tick_s && !up_dn;
        end else begin : g_upper
            assign inc_s[g] = inc_s[g-1] && wrap_s[g-1];
            assign dec_s[g] = dec_s[g-1] && wrap_s[g-1];
        end

        bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .inc      (inc_s[g]),
            .dec      (dec_s[g]),
            .load     (load),
            .ld_val   (load_val[4*g +: 4]),
            .q        (count_s[4*g +: 4]),
            .wrap_out (wrap_s[g])
        );
    end

    // Full-width wrap pulse and display common enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_r   <= 1'b0;
            led_com_r <= 1'b0;
        end else begin
            carry_r   <= load ? 1'b0 : wrap_s[NUM_DIGITS-1];
            led_com_r <= 1'b1;
        end
    end

    // Scan slot timer and digit selector; runs regardless of enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_r <= '0;
            sel_r  <= '0;
        end else if (scan_wrap_s) begin
            scan_r <= '0;
            sel_r  <= (sel_r == SEL_W'(NUM_DIGITS - 1)) ? SEL_W'(0) : sel_r + SEL_W'(1);
        end else begin
            scan_r <= scan_r + SCAN_W'(1);
            sel_r  <= sel_r;
        end
    end

    // zero_above_s[i] is set when digits i..NUM_DIGITS-1 are all zero.
    always_comb begin
        logic acc;
        acc          = 1'b1;
        zero_above_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc             = acc && (count_s[4*i +: 4] == 4'd0);
            zero_above_s[i] = acc;
        end
    end

    // Pick the selected digit and decide whether it is a blanked leading zero.
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_s = (sel_r == SEL_W'(i)) ? count_s[4*i +: 4] : digit_s;
            blank_s = (sel_r == SEL_W'(i)) ? (blank_lz && (i != 0) && zero_above_s[i]) : blank_s;
        end
    end

    assign count_out = count_s;
    assign carry     = carry_r;
    assign seg7_sel  = sel_r;
    assign led_com   = led_com_r;
    assign seg7_out  = blank_s ? SEG_BLANK : seg_decode(digit_s);
    assign dpt       = (sel_r == SEL_W'(DP_POS));

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: two instances (TICK_DIV 1 and 4) checked every cycle against a decimal-integer model.
module tb_bcd_scan_counter;

    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        reset, enable, up_dn, load, blank_lz;
    logic [23:0] load_val;

    logic [23:0] count_a, count_b;
    logic        carry_a, carry_b, dpt_a, dpt_b, led_com_a, led_com_b;
    logic [2:0]  sel_a, sel_b;
    logic [6:0]  seg_a, seg_b;

    int checks = 0;
    int failures = 0;

    int  m_cnt[2], m_presc[2], m_scan[2], m_sel[2];
    bit  m_carry[2], m_lc[2];
    bit  m_valid = 1'b0;
    int  td[2] = '{1, 4};

    always #5 clk = ~clk;

    bcd_scan_counter #(.NUM_DIGITS(6), .SEL_W(3), .TICK_DIV(1), .SCAN_DIV(SD), .DP_POS(2)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .blank_lz(blank_lz), .count_out(count_a), .carry(carry_a),
        .seg7_sel(sel_a), .seg7_out(seg_a), .dpt(dpt_a), .led_com(led_com_a));

    bcd_scan_counter #(.NUM_DIGITS(6), .SEL_W(3), .TICK_DIV(4), .SCAN_DIV(SD), .DP_POS(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .blank_lz(blank_lz), .count_out(count_b), .carry(carry_b),
        .seg7_sel(sel_b), .seg7_out(seg_b), .dpt(dpt_b), .led_com(led_com_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1111110;  1: return 7'b0110000;
            2: return 7'b1101101;  3: return 7'b1111001;
            4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;
            8: return 7'b1111111;  9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int t;
        t = v;
        r = 24'h0;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [23:0] lv);
        int v, p, d;
        v = 0;
        p = 1;
        for (int k = 0; k < 6; k++) begin
            d = int'(lv[4*k +: 4]);
            v = v + ((d > 9) ? 0 : d) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [6:0] exp_seg(input int cnt, input int sel, input bit blz);
        int p;
        p = 1;
        for (int k = 0; k < sel; k++) p = p * 10;
        if (blz && sel > 0 && cnt < p) return 7'b0000000;
        return seg_of((cnt / p) % 10);
    endfunction

    task automatic cmp_inst(input int k, input string tag, input logic [23:0] c, input logic cy,
                            input logic [2:0] s, input logic [6:0] sg, input logic dp, input logic lc);
        chk({tag, "_count"}, 32'(c), 32'(to_bcd(m_cnt[k])));
        chk({tag, "_carry"}, 32'(cy), 32'(m_carry[k]));
        chk({tag, "_sel"}, 32'(s), 32'(m_sel[k]));
        chk({tag, "_seg"}, 32'(sg), 32'(exp_seg(m_cnt[k], m_sel[k], blank_lz)));
        chk({tag, "_dpt"}, 32'(dp), 32'(m_sel[k] == 2));
        chk({tag, "_ledcom"}, 32'(lc), 32'(m_lc[k]));
    endtask

    // Model update on each rising edge from the inputs held stable since the last falling edge, then compare.
    initial begin
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    m_cnt[k] = 0; m_presc[k] = 0; m_scan[k] = 0; m_sel[k] = 0;
                    m_carry[k] = 1'b0; m_lc[k] = 1'b0;
                end else begin
                    m_lc[k] = 1'b1;
                    if (m_scan[k] == SD - 1) begin
                        m_scan[k] = 0;
                        m_sel[k] = (m_sel[k] + 1) % 6;
                    end else begin
                        m_scan[k]++;
                    end
                    m_carry[k] = 1'b0;
                    if (load) begin
                        m_cnt[k] = from_load(load_val);
                        m_presc[k] = 0;
                    end else if (enable) begin
                        if (m_presc[k] == td[k] - 1) begin
                            m_presc[k] = 0;
                            if (up_dn) begin
                                m_carry[k] = (m_cnt[k] == 999999);
                                m_cnt[k] = (m_cnt[k] + 1) % 1000000;
                            end else begin
                                m_carry[k] = (m_cnt[k] == 0);
                                m_cnt[k] = (m_cnt[k] + 999999) % 1000000;
                            end
                        end else begin
                            m_presc[k]++;
                        end
                    end
                end
            end
            if (reset) m_valid = 1'b1;
            #1;
            if (m_valid) begin
                cmp_inst(0, "a", count_a, carry_a, sel_a, seg_a, dpt_a, led_com_a);
                cmp_inst(1, "b", count_b, carry_b, sel_b, seg_b, dpt_b, led_com_b);
            end
        end
    end

    logic [6:0] tbl_blank[6]   = '{7'b1011011, 7'b1111110, 7'b0110000, 7'b0000000, 7'b0000000, 7'b0000000};
    logic [6:0] tbl_noblank[6] = '{7'b1011011, 7'b1111110, 7'b0110000, 7'b1111110, 7'b1111110, 7'b1111110};

    initial begin
        bit found;
        reset = 1'b1; enable = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 24'h0; blank_lz = 1'b0;

        // Reset and idle
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_ledcom", 32'(led_com_a), 32'h0);
        chk("rst_count", 32'(count_a), 32'h0);
        chk("rst_seg", 32'(seg_a), 32'h7e);
        reset = 1'b0;
        @(negedge clk);
        chk("ledcom_after", 32'(led_com_a), 32'h1);
        repeat (100) @(negedge clk);
        chk("idle_count_a", 32'(count_a), 32'h0);
        chk("idle_count_b", 32'(count_b), 32'h0);

        // Up ripple and wrap
        load = 1'b1; load_val = 24'h999998; up_dn = 1'b1; enable = 1'b1;
        @(negedge clk); load = 1'b0;
        chk("up_load", 32'(count_a), 32'h999998);
        @(negedge clk); chk("up_999999", 32'(count_a), 32'h999999); chk("up_c0", 32'(carry_a), 32'h0);
        @(negedge clk); chk("up_wrap", 32'(count_a), 32'h000000); chk("up_c1", 32'(carry_a), 32'h1);
        @(negedge clk); chk("up_000001", 32'(count_a), 32'h000001); chk("up_c2", 32'(carry_a), 32'h0);

        // Down wrap
        load = 1'b1; load_val = 24'h000001; up_dn = 1'b0;
        @(negedge clk); load = 1'b0;
        chk("dn_load", 32'(count_a), 32'h000001);
        @(negedge clk); chk("dn_000000", 32'(count_a), 32'h000000); chk("dn_c0", 32'(carry_a), 32'h0);
        @(negedge clk); chk("dn_wrap", 32'(count_a), 32'h999999); chk("dn_c1", 32'(carry_a), 32'h1);
        @(negedge clk); chk("dn_999998", 32'(count_a), 32'h999998); chk("dn_c2", 32'(carry_a), 32'h0);

        // Load on a tick cycle of the TICK_DIV=4 instance
        up_dn = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            if (m_presc[1] == 3) found = 1'b1;
            else @(negedge clk);
        end
        chk("tick_found", 32'(found), 32'h1);
        load = 1'b1; load_val = 24'h12AF34;
        @(negedge clk); load = 1'b0;
        chk("ld_prio", 32'(count_b), 32'h120034);
        chk("ld_carry", 32'(carry_b), 32'h0);
        repeat (3) begin
            @(negedge clk); chk("ld_hold", 32'(count_b), 32'h120034);
        end
        @(negedge clk); chk("ld_next_tick", 32'(count_b), 32'h120035);

        // Enable low freezes the count
        enable = 1'b0;
        repeat (10) begin
            @(negedge clk); chk("en_frozen", 32'(count_b), 32'h120035);
        end

        // Direction changes take effect on the next tick only
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("dir_up", 32'(count_b), 32'h120036);
        repeat (2) @(negedge clk);
        up_dn = 1'b0;
        @(negedge clk); chk("dir_mid", 32'(count_b), 32'h120036);
        @(negedge clk); chk("dir_dn", 32'(count_b), 32'h120035);
        up_dn = 1'b1;
        repeat (4) @(negedge clk);
        chk("dir_up2", 32'(count_b), 32'h120036);

        // Scan with and without leading-zero blanking
        enable = 1'b0; load = 1'b1; load_val = 24'h000105; blank_lz = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (12) begin
            chk("scan_blank_a", 32'(seg_a), 32'(tbl_blank[m_sel[0]]));
            chk("scan_blank_b", 32'(seg_b), 32'(tbl_blank[m_sel[1]]));
            chk("scan_dpt", 32'(dpt_a), 32'(m_sel[0] == 2));
            @(negedge clk);
        end
        blank_lz = 1'b0;
        #1;
        repeat (12) begin
            chk("scan_noblank", 32'(seg_a), 32'(tbl_noblank[m_sel[0]]));
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
